// File: rtl/warpse_slow_pkg.sv
// -----------------------------------------------------------------------------
// warpse_slow_pkg
// Shared types and constants for the slow-access controller.
//   slow_state_t      : controller state (IDLE, ACCESS, HOLD)
//   SLOW_CNT_W        : width of the hold-tick counter / timeout field
//   SLOW_PRE_DIV_DEF  : default CLK cycles per timeout tick
// -----------------------------------------------------------------------------
package warpse_slow_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HOLD   = 2'd2
    } slow_state_t;

    localparam int SLOW_CNT_W       = 4;
    localparam int SLOW_PRE_DIV_DEF = 16;

endpackage

// File: rtl/slow_tick.sv
// -----------------------------------------------------------------------------
// slow_tick
// Free-running prescaler. It counts 0..PRE_DIV-1 and raises Tick for the one
// cycle in which the count sits at PRE_DIV-1. On the next edge the count wraps
// to 0. The phase is never resynchronised to bus activity.
// Parameters:
//   PRE_DIV : CLK cycles per tick (2..256)
// Ports:
//   CLK  in   system clock
//   nPOR in   synchronous active-low reset (count forced to 0)
//   Tick out  one-cycle pulse every PRE_DIV cycles
// -----------------------------------------------------------------------------
module slow_tick
    import warpse_slow_pkg::*;
#(
    parameter int PRE_DIV = SLOW_PRE_DIV_DEF
) (
    input  logic CLK,
    input  logic nPOR,
    output logic Tick
);

    localparam int CW = $clog2(PRE_DIV);
    localparam logic [CW-1:0] LAST = CW'(PRE_DIV - 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples the values from before the clock edge.
    always_ff @(posedge CLK) begin
        if (!nPOR) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign Tick = (cnt == LAST);

endmodule

// File: rtl/slow_ctl.sv
// -----------------------------------------------------------------------------
// slow_ctl
// Turns the slow-access configuration into a live slow-mode request. A rising
// edge of BACT that hits an enabled slow region starts a request. The request
// lasts while the access is active and for SlowTimeout prescaler ticks after
// it ends. The fast clock is gated while the request is active, when enabled.
//
// Build option: define SLOW_SND_EN to let sound-buffer writes
// (SndCSWR && SlowSnd) count as slow hits. If it is undefined, both inputs are
// ignored, but the ports remain.
//
// Parameters:
//   PRE_DIV       : CLK cycles per timeout tick (2..256)
// Ports:
//   CLK           in   system clock
//   nPOR          in   synchronous active-low reset
//   BACT          in   CPU bus cycle active
//   IACKCS..SCSICS in  address-decode hits for the current cycle
//   SndCSWR       in   sound-buffer write hit (SLOW_SND_EN only)
//   SlowIACK..SlowSnd in per-region slow enables
//   SlowClockGate in   allow gating of the fast clock
//   SlowTimeout   in   hold time in ticks, sampled when the access ends
//   SlowActive    out  slow-mode request
//   ClockGate     out  SlowActive && SlowClockGate, one cycle later
//   SlowCnt       out  remaining hold ticks (debug)
// -----------------------------------------------------------------------------
module slow_ctl
    import warpse_slow_pkg::*;
#(
    parameter int PRE_DIV = SLOW_PRE_DIV_DEF
) (
    input  logic                  CLK,
    input  logic                  nPOR,
    input  logic                  BACT,
    input  logic                  IACKCS,
    input  logic                  VIACS,
    input  logic                  IWMCS,
    input  logic                  SCCCS,
    input  logic                  SCSICS,
    input  logic                  SndCSWR,
    input  logic                  SlowIACK,
    input  logic                  SlowVIA,
    input  logic                  SlowIWM,
    input  logic                  SlowSCC,
    input  logic                  SlowSCSI,
    input  logic                  SlowSnd,
    input  logic                  SlowClockGate,
    input  logic [SLOW_CNT_W-1:0] SlowTimeout,
    output logic                  SlowActive,
    output logic                  ClockGate,
    output logic [SLOW_CNT_W-1:0] SlowCnt
);

    slow_state_t           state_q, state_d;
    logic [SLOW_CNT_W-1:0] cnt_q, cnt_d;
    logic                  bactr_q;
    logic                  gate_q;
    logic                  tick;
    logic                  snd_hit;
    logic                  hit;
    logic                  trigger;

    slow_tick #(.PRE_DIV(PRE_DIV)) u_tick (
        .CLK  (CLK),
        .nPOR (nPOR),
        .Tick (tick)
    );

`ifdef SLOW_SND_EN
    assign snd_hit = SndCSWR && SlowSnd;
`else
    logic unused_snd;
    assign unused_snd = SndCSWR ^ SlowSnd;
    assign snd_hit    = 1'b0;
`endif

    assign hit = (IACKCS && SlowIACK) || (VIACS && SlowVIA) || (IWMCS && SlowIWM)
              || (SCCCS && SlowSCC) || (SCSICS && SlowSCSI) || snd_hit;

    // Only the first cycle of a bus access can trigger. The enables and the
    // chip selects are ignored after that cycle.
    assign trigger = BACT && !bactr_q && hit;

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!BACT) begin
                    if (SlowTimeout == '0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = HOLD;
                        cnt_d   = SlowTimeout;
                    end
                end
            end
            HOLD: begin
                // A new access has priority over a tick in the same cycle.
                // The remaining count is kept.
                if (trigger) begin
                    state_d = ACCESS;
                end else if (tick) begin
                    if (cnt_q == SLOW_CNT_W'(1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - SLOW_CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nPOR) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bactr_q <= 1'b0;
            gate_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bactr_q <= BACT;
            gate_q  <= (state_q != IDLE) && SlowClockGate;
        end
    end

    assign SlowActive = (state_q != IDLE);
    assign ClockGate  = gate_q;
    assign SlowCnt    = cnt_q;

endmodule

// File: tb/tb_slow_ctl.sv
// -----------------------------------------------------------------------------
// tb_slow_ctl
// Directed bench for slow_ctl (PRE_DIV = 16). The stimulus pushes the expected
// snapshots and pulse lengths into queues. A monitor on the falling clock edge
// pops the snapshots and compares them. It also measures each SlowActive pulse
// and compares its length with the next pulse expectation.
// -----------------------------------------------------------------------------
module tb_slow_ctl;

    logic       CLK = 1'b0;
    logic       nPOR, BACT;
    logic       IACKCS, VIACS, IWMCS, SCCCS, SCSICS, SndCSWR;
    logic       SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd;
    logic       SlowClockGate;
    logic [3:0] SlowTimeout;
    logic       SlowActive, ClockGate;
    logic [3:0] SlowCnt;

    always #5 CLK = ~CLK;

    slow_ctl #(.PRE_DIV(16)) dut (
        .CLK           (CLK),
        .nPOR          (nPOR),
        .BACT          (BACT),
        .IACKCS        (IACKCS),
        .VIACS         (VIACS),
        .IWMCS         (IWMCS),
        .SCCCS         (SCCCS),
        .SCSICS        (SCSICS),
        .SndCSWR       (SndCSWR),
        .SlowIACK      (SlowIACK),
        .SlowVIA       (SlowVIA),
        .SlowIWM       (SlowIWM),
        .SlowSCC       (SlowSCC),
        .SlowSCSI      (SlowSCSI),
        .SlowSnd       (SlowSnd),
        .SlowClockGate (SlowClockGate),
        .SlowTimeout   (SlowTimeout),
        .SlowActive    (SlowActive),
        .ClockGate     (ClockGate),
        .SlowCnt       (SlowCnt)
    );

    typedef struct {
        string      name;
        logic       act;
        logic       gate;
        logic [3:0] cnt;
        bit         chk_cnt;
    } snap_t;

    typedef struct {
        string name;
        int    lo;
        int    hi;
        bit    chk;
    } pulse_t;

    snap_t  snap_q[$];
    pulse_t pulse_q[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    int     plen  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic exp_snap(input string name, input logic act, input logic gate,
                            input logic [3:0] cnt, input bit chk_cnt);
        snap_t s;
        s.name = name; s.act = act; s.gate = gate; s.cnt = cnt; s.chk_cnt = chk_cnt;
        snap_q.push_back(s);
    endtask

    task automatic exp_pulse(input string name, input int lo, input int hi, input bit chk);
        pulse_t p;
        p.name = name; p.lo = lo; p.hi = hi; p.chk = chk;
        pulse_q.push_back(p);
    endtask

    // Polls until SlowCnt reaches the value or the cycle budget runs out.
    task automatic wait_cnt(input string name, input logic [3:0] value, input int budget);
        int n = 0;
        while (SlowCnt !== value && n < budget) begin
            step();
            n++;
        end
        check(name, SlowCnt, value);
    endtask

    // Monitor: compares queued snapshots and measures SlowActive pulses.
    always @(negedge CLK) begin
        while (snap_q.size() > 0) begin
            snap_t s;
            s = snap_q.pop_front();
            check({s.name, "_act"}, SlowActive, s.act);
            check({s.name, "_gate"}, ClockGate, s.gate);
            if (s.chk_cnt) check({s.name, "_cnt"}, SlowCnt, s.cnt);
        end
        if (SlowActive === 1'b1) begin
            plen++;
        end else if (plen > 0) begin
            if (pulse_q.size() == 0) begin
                check("unexpected_pulse_len", plen, 0);
            end else begin
                pulse_t p;
                p = pulse_q.pop_front();
                if (p.chk) check_range({p.name, "_pulse_len"}, plen, p.lo, p.hi);
            end
            plen = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        nPOR = 1'b0; BACT = 1'b0;
        IACKCS = 1'b0; VIACS = 1'b0; IWMCS = 1'b0; SCCCS = 1'b0; SCSICS = 1'b0; SndCSWR = 1'b0;
        SlowIACK = 1'b0; SlowVIA = 1'b0; SlowIWM = 1'b0; SlowSCC = 1'b0; SlowSCSI = 1'b0; SlowSnd = 1'b0;
        SlowClockGate = 1'b0; SlowTimeout = 4'd0;

        // Reset state.
        steps(2);
        exp_snap("reset", 1'b0, 1'b0, 4'd0, 1'b1);
        step();
        nPOR = 1'b1;
        steps(3);

        // VIA access, timeout 2, BACT high for 4 cycles. The pulse is 4 access
        // cycles plus 17..32 hold cycles.
        SlowVIA = 1'b1; SlowTimeout = 4'd2; SlowClockGate = 1'b1;
        exp_pulse("via", 4 + 17, 4 + 32, 1'b1);
        BACT = 1'b1; VIACS = 1'b1;
        exp_snap("via_pre", 1'b0, 1'b0, 4'd0, 1'b1);
        step();
        exp_snap("via_rise", 1'b1, 1'b0, 4'd0, 1'b1);
        step();
        exp_snap("via_gate", 1'b1, 1'b1, 4'd0, 1'b1);
        steps(2);
        BACT = 1'b0; VIACS = 1'b0;
        step();
        exp_snap("via_hold_load", 1'b1, 1'b1, 4'd2, 1'b1);
        steps(40);
        exp_snap("via_done", 1'b0, 1'b0, 4'd0, 1'b1);
        steps(2);

        // SCSI access while its enable is clear: there is no request.
        SlowSCSI = 1'b0;
        BACT = 1'b1; SCSICS = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            exp_snap("scsi_off", 1'b0, 1'b0, 4'd0, 1'b1);
        end
        BACT = 1'b0; SCSICS = 1'b0;
        steps(3);

        // IWM access, timeout 0, clock gating enabled and then disabled.
        SlowIWM = 1'b1; SlowTimeout = 4'd0;
        for (int g = 1; g >= 0; g--) begin
            logic gv;
            gv = (g == 1);
            SlowClockGate = gv;
            exp_pulse("iwm", 4, 4, 1'b1);
            BACT = 1'b1; IWMCS = 1'b1;
            step();
            exp_snap("iwm_rise", 1'b1, 1'b0, 4'd0, 1'b0);
            steps(3);
            exp_snap("iwm_last", 1'b1, gv, 4'd0, 1'b0);
            BACT = 1'b0; IWMCS = 1'b0;
            step();
            exp_snap("iwm_drop", 1'b0, gv, 4'd0, 1'b0);
            step();
            exp_snap("iwm_gate_off", 1'b0, 1'b0, 4'd0, 1'b0);
            steps(3);
        end
        SlowIWM = 1'b0;

        // Retrigger from HOLD with SlowCnt=1 on the cycle that Tick is high.
        SlowSCC = 1'b1; SlowTimeout = 4'd2; SlowClockGate = 1'b0;
        exp_pulse("scc", 0, 0, 1'b0);
        BACT = 1'b1; SCCCS = 1'b1;
        steps(2);
        BACT = 1'b0; SCCCS = 1'b0;
        step();
        exp_snap("scc_hold", 1'b1, 1'b0, 4'd2, 1'b1);
        wait_cnt("scc_reach_1", 4'd1, 40);
        steps(15);
        BACT = 1'b1; SCCCS = 1'b1;
        step();
        exp_snap("scc_retrig", 1'b1, 1'b0, 4'd1, 1'b1);
        SlowTimeout = 4'd3;
        SCCCS = 1'b0;
        step();
        exp_snap("scc_access", 1'b1, 1'b0, 4'd1, 1'b1);
        BACT = 1'b0;
        step();
        // Coming from ACCESS, the count is reloaded with the new timeout.
        exp_snap("scc_reload", 1'b1, 1'b0, 4'd3, 1'b1);
        // Later changes to the timeout and enable leave the running hold alone.
        SlowTimeout = 4'd0; SlowSCC = 1'b0;
        steps(14);
        exp_snap("scc_tick1", 1'b1, 1'b0, 4'd2, 1'b1);
        steps(31);
        exp_snap("scc_last", 1'b1, 1'b0, 4'd1, 1'b1);
        step();
        exp_snap("scc_end", 1'b0, 1'b0, 4'd0, 1'b1);
        steps(3);

        // Reset in HOLD with SlowTimeout=4 and SlowCnt=3.
        SlowVIA = 1'b1; SlowTimeout = 4'd4; SlowClockGate = 1'b1;
        exp_pulse("rst", 0, 0, 1'b0);
        BACT = 1'b1; VIACS = 1'b1;
        steps(2);
        BACT = 1'b0; VIACS = 1'b0;
        step();
        exp_snap("rst_hold", 1'b1, 1'b1, 4'd4, 1'b1);
        wait_cnt("rst_reach_3", 4'd3, 40);
        exp_snap("rst_pre", 1'b1, 1'b1, 4'd3, 1'b1);
        nPOR = 1'b0;
        step();
        exp_snap("rst_post", 1'b0, 1'b0, 4'd0, 1'b1);
        nPOR = 1'b1;
        step();
        exp_snap("rst_after", 1'b0, 1'b0, 4'd0, 1'b1);
        steps(2);
        SlowVIA = 1'b0;

        // Sound write with SlowSnd=1 and SlowTimeout=0.
        SlowSnd = 1'b1; SlowTimeout = 4'd0; SlowClockGate = 1'b0;
`ifdef SLOW_SND_EN
        exp_pulse("snd", 3, 3, 1'b1);
        BACT = 1'b1; SndCSWR = 1'b1;
        step();
        exp_snap("snd_on", 1'b1, 1'b0, 4'd0, 1'b0);
`else
        BACT = 1'b1; SndCSWR = 1'b1;
        step();
        exp_snap("snd_off", 1'b0, 1'b0, 4'd0, 1'b1);
`endif
        steps(2);
        BACT = 1'b0; SndCSWR = 1'b0;
        step();
        exp_snap("snd_end", 1'b0, 1'b0, 4'd0, 1'b0);
        steps(4);

        check("pulse_queue_left", pulse_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
